// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared defaults and state type for the SPI responder
package spi_pkg;

  localparam int SPI_WIDTH       = 16;
  localparam int SPI_SYNC_STAGES = 2;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } spi_state_e;

endpackage

// File: rtl/spi_responder_sync_edge.sv
// rtl/spi_responder_sync_edge.sv - input synchronizer with rise/fall strobes
module sync_edge
  import spi_pkg::*;
#(
  parameter int   STAGES    = SPI_SYNC_STAGES,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din_i,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Synchronizer chain plus one history flop; the history flop starts at the
  // same level as the chain so no strobe fires out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign rise_o = sync_q[STAGES-1] & ~prev_q;
  assign fall_o = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_responder.sv
// rtl/spi_responder.sv - SPI mode-0 responder with oversampled serial inputs
module spi_responder
  import spi_pkg::*;
#(
  parameter int WIDTH       = SPI_WIDTH,
  parameter int SYNC_STAGES = SPI_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             SCLK,
  input  logic             CS_n,
  input  logic             MOSI,
  output logic             MISO,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             tx_underrun,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic sclk_rise, sclk_fall;
  logic cs_rise, cs_fall;

  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic                   mosi_s;

  spi_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] shin_q, shin_d;
  logic [WIDTH-1:0] shout_q, shout_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             miso_q;
  logic             load;

  sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
    .clk    (clk),
    .rst_n  (reset),
    .din_i  (SCLK),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .clk    (clk),
    .rst_n  (reset),
    .din_i  (CS_n),
    .rise_o (cs_rise),
    .fall_o (cs_fall)
  );

  // MOSI only needs the synchronizer; its delay matches the SCLK strobe path.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) mosi_sync_q <= '0;
    else        mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
  end

  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  // Transfer state, shift registers, received word and registered MISO.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      shin_q     <= '0;
      shout_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      miso_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shin_q     <= shin_d;
      shout_q    <= shout_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      miso_q     <= (state_q == ST_ACTIVE) ? shout_q[WIDTH-1] : 1'b0;
    end
  end

  // Next-state: CS_n rise outranks any SCLK edge in the same cycle, and a
  // falling SCLK with the bit counter at zero starts the next word.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shin_d      = shin_q;
    shout_d     = shout_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    tx_ready    = 1'b0;
    tx_underrun = 1'b0;
    load        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          state_d = ST_ACTIVE;
          cnt_d   = '0;
          load    = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (cs_rise) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          shin_d  = '0;
        end else begin
          if (sclk_rise) begin
            shin_d = {shin_q[WIDTH-2:0], mosi_s};
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
              cnt_d      = '0;
              rx_data_d  = shin_d;
              rx_valid_d = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
          if (sclk_fall) begin
            if (cnt_q == '0) load = 1'b1;
            else             shout_d = shout_q << 1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load) begin
      if (tx_valid) begin
        shout_d  = tx_data;
        tx_ready = 1'b1;
      end else begin
        shout_d     = '0;
        tx_underrun = 1'b1;
      end
    end
  end

  assign MISO     = miso_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_responder.sv
// tb/tb_spi_responder.sv - self-checking bench for spi_responder
module tb_spi_responder;

  logic        clk;
  logic        reset;
  logic        SCLK, CS_n, MOSI, MISO;
  logic [15:0] tx_data;
  logic        tx_valid, tx_ready, tx_underrun;
  logic [15:0] rx_data;
  logic        rx_valid;

  int checks = 0;
  int errors = 0;
  int ready_cnt = 0;
  int underrun_cnt = 0;
  int rx_cnt = 0;

  logic [15:0] exp_rx_q[$];
  logic [15:0] tx_q[$];
  logic [15:0] mon_exp;
  logic        seen_ready;

  typedef struct {
    logic [15:0] mosi_word;
    logic        tx_en;
    logic [15:0] tx_word;
    logic [15:0] exp_rx;
    logic [15:0] exp_miso;
    int          exp_ready;
    int          exp_underrun;
  } vec_t;

  vec_t vecs[5];

  spi_responder dut (
    .clk         (clk),
    .reset       (reset),
    .SCLK        (SCLK),
    .CS_n        (CS_n),
    .MOSI        (MOSI),
    .MISO        (MISO),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_underrun (tx_underrun),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Receive scoreboard: every rx_valid must match the oldest expected word.
  always @(negedge clk) begin
    if (reset && rx_valid) begin
      rx_cnt++;
      checks++;
      if (exp_rx_q.size() == 0) begin
        errors++;
        $display("FAIL rx_unexpected actual=%h required=none", rx_data);
      end else begin
        mon_exp = exp_rx_q.pop_front();
        if (rx_data !== mon_exp) begin
          errors++;
          $display("FAIL rx_word actual=%h required=%h", rx_data, mon_exp);
        end
      end
    end
  end

  // Transmit feeder: presents the head of tx_q, pops it after a tx_ready cycle.
  initial begin
    tx_valid = 1'b0;
    tx_data  = '0;
    forever begin
      @(negedge clk);
      seen_ready = tx_ready;
      if (tx_ready) ready_cnt++;
      if (tx_underrun) underrun_cnt++;
      @(posedge clk);
      #1;
      if (seen_ready && tx_q.size() > 0) void'(tx_q.pop_front());
      tx_valid = (tx_q.size() > 0);
      tx_data  = (tx_q.size() > 0) ? tx_q[0] : 16'h0000;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Initiator side of mode 0: MISO sampled and MOSI launched around SCLK rise.
  task automatic xfer(input logic [15:0] w, input int nbits, output logic [15:0] m);
    m = '0;
    for (int i = 15; i > 15 - nbits; i--) begin
      MOSI = w[i];
      wait_clk(4);
      m[i] = MISO;
      SCLK = 1'b1;
      wait_clk(4);
      SCLK = 1'b0;
    end
  endtask

  initial begin
    logic [15:0] m0, m1;
    int r0, u0, x0;

    vecs[0] = '{16'h3C0F, 1'b1, 16'hA55A, 16'h3C0F, 16'hA55A, 1, 1};
    vecs[1] = '{16'h1234, 1'b0, 16'h0000, 16'h1234, 16'h0000, 0, 2};
    vecs[2] = '{16'hFFFF, 1'b1, 16'h0000, 16'hFFFF, 16'h0000, 1, 1};
    vecs[3] = '{16'h0000, 1'b1, 16'hFFFF, 16'h0000, 16'hFFFF, 1, 1};
    vecs[4] = '{16'h8001, 1'b1, 16'h7FFE, 16'h8001, 16'h7FFE, 1, 1};

    reset = 1'b0;
    SCLK  = 1'b0;
    CS_n  = 1'b1;
    MOSI  = 1'b0;
    wait_clk(3);
    check("reset_miso", MISO, 0);
    check("reset_rx_data", rx_data, 0);
    check("reset_rx_valid", rx_valid, 0);
    check("reset_tx_ready", tx_ready, 0);
    check("reset_tx_underrun", tx_underrun, 0);
    reset = 1'b1;
    wait_clk(3);

    // SCLK activity with CS_n high must be ignored.
    for (int i = 0; i < 10; i++) begin
      MOSI = i[0];
      SCLK = 1'b1;
      wait_clk(4);
      SCLK = 1'b0;
      wait_clk(4);
    end
    check("idle_miso", MISO, 0);
    check("idle_rx_count", rx_cnt, 0);
    check("idle_ready_count", ready_cnt, 0);
    check("idle_underrun_count", underrun_cnt, 0);

    // Single-word transfers from the vector table.
    for (int v = 0; v < 5; v++) begin
      r0 = ready_cnt; u0 = underrun_cnt; x0 = rx_cnt;
      exp_rx_q.push_back(vecs[v].exp_rx);
      if (vecs[v].tx_en) tx_q.push_back(vecs[v].tx_word);
      wait_clk(3);
      CS_n = 1'b0;
      wait_clk(6);
      check($sformatf("v%0d_ready_at_cs_fall", v), ready_cnt - r0, vecs[v].exp_ready);
      xfer(vecs[v].mosi_word, 16, m0);
      wait_clk(4);
      CS_n = 1'b1;
      wait_clk(6);
      check($sformatf("v%0d_miso_word", v), m0, vecs[v].exp_miso);
      check($sformatf("v%0d_rx_data", v), rx_data, vecs[v].exp_rx);
      check($sformatf("v%0d_rx_count", v), rx_cnt - x0, 1);
      check($sformatf("v%0d_ready_count", v), ready_cnt - r0, vecs[v].exp_ready);
      check($sformatf("v%0d_underrun_count", v), underrun_cnt - u0, vecs[v].exp_underrun);
    end

    // Back-to-back words under one chip select.
    r0 = ready_cnt; u0 = underrun_cnt; x0 = rx_cnt;
    exp_rx_q.push_back(16'h1234);
    exp_rx_q.push_back(16'hFFFF);
    tx_q.push_back(16'h0001);
    tx_q.push_back(16'h8000);
    wait_clk(3);
    CS_n = 1'b0;
    wait_clk(6);
    xfer(16'h1234, 16, m0);
    check("b2b_ready_after_word1", ready_cnt - r0, 1);
    xfer(16'hFFFF, 16, m1);
    wait_clk(4);
    CS_n = 1'b1;
    wait_clk(6);
    check("b2b_miso_word1", m0, 16'h0001);
    check("b2b_miso_word2", m1, 16'h8000);
    check("b2b_rx_count", rx_cnt - x0, 2);
    check("b2b_rx_data", rx_data, 16'hFFFF);
    check("b2b_ready_count", ready_cnt - r0, 2);
    check("b2b_underrun_count", underrun_cnt - u0, 1);

    // Partial word aborted by CS_n rise, then a full word.
    x0 = rx_cnt;
    CS_n = 1'b0;
    wait_clk(6);
    xfer(16'h1357, 7, m0);
    wait_clk(4);
    CS_n = 1'b1;
    wait_clk(6);
    check("partial_rx_count", rx_cnt - x0, 0);
    check("partial_rx_data_held", rx_data, 16'hFFFF);
    exp_rx_q.push_back(16'hBEEF);
    CS_n = 1'b0;
    wait_clk(6);
    xfer(16'hBEEF, 16, m0);
    wait_clk(4);
    CS_n = 1'b1;
    wait_clk(6);
    check("after_partial_rx_count", rx_cnt - x0, 1);
    check("after_partial_rx_data", rx_data, 16'hBEEF);

    // Reset asserted in the middle of bit 9 with SCLK high.
    CS_n = 1'b0;
    wait_clk(6);
    xfer(16'hCAFE, 8, m0);
    MOSI = 1'b1;
    wait_clk(4);
    SCLK = 1'b1;
    wait_clk(1);
    reset = 1'b0;
    wait_clk(1);
    check("midreset_miso", MISO, 0);
    check("midreset_rx_data", rx_data, 0);
    check("midreset_rx_valid", rx_valid, 0);
    check("midreset_tx_ready", tx_ready, 0);
    check("midreset_tx_underrun", tx_underrun, 0);
    SCLK = 1'b0;
    CS_n = 1'b1;
    wait_clk(3);
    reset = 1'b1;
    wait_clk(4);
    x0 = rx_cnt;
    exp_rx_q.push_back(16'h5A5A);
    tx_q.push_back(16'h0F0F);
    wait_clk(3);
    CS_n = 1'b0;
    wait_clk(6);
    xfer(16'h5A5A, 16, m0);
    wait_clk(4);
    CS_n = 1'b1;
    wait_clk(6);
    check("postreset_miso_word", m0, 16'h0F0F);
    check("postreset_rx_data", rx_data, 16'h5A5A);
    check("postreset_rx_count", rx_cnt - x0, 1);
    check("scoreboard_drained", exp_rx_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
